// File: rtl/adjust_sched_if.sv
// Key/select inputs and pulse/level outputs of adjust_sched; master is the board/SW side, slave the scheduler.
interface adjust_sched_if #(
  parameter int NUM_FILTERS = 4
);
  localparam int SW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic                   enable;
  logic                   frame_en;
  logic                   key_inc_n;
  logic                   key_dec_n;
  logic [SW-1:0]          sel;
  logic [NUM_FILTERS-1:0] inc;
  logic [NUM_FILTERS-1:0] dec;
  logic [3:0]             level;
  logic                   pending;

  modport master (
    output enable, frame_en, key_inc_n, key_dec_n, sel,
    input  inc, dec, level, pending
  );

  modport slave (
    input  enable, frame_en, key_inc_n, key_dec_n, sel,
    output inc, dec, level, pending
  );
endinterface

// File: rtl/adjust_sched.sv
// adjust_sched: debounced adjust keys -> frame-aligned one-hot inc/dec pulses with saturating per-filter levels; AUTOREPEAT_EN adds key auto-repeat.
// Latency: pulse on the first frame_en after the press event; no backpressure, presses during pend/issue are dropped or cancel.
module adjust_sched #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_FILTERS     = 4,
  parameter int LEVEL_MAX       = 7,
  parameter int LEVEL_DEFAULT   = 4,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 32
) (
  input  logic          clk,
  input  logic          rst,
  adjust_sched_if.slave sif
);
  localparam int SW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    LV_MAX   = 4'(LEVEL_MAX);
  localparam logic [3:0]    LV_DEF   = 4'(LEVEL_DEFAULT);

  typedef enum logic [1:0] {IDLE, PEND_INC, PEND_DEC, ISSUE} state_t;

  // Index 0 is the increase key, index 1 the decrease key; 1 means pressed.
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, stable, press_ev, key_ev;
  logic [CW-1:0] db_cnt [2];

  assign raw = {~sif.key_dec_n, ~sif.key_inc_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      press_ev <= '0;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int k = 0; k < 2; k++) begin
        press_ev[k] <= sync2[k] && !stable[k] && (db_cnt[k] == CNT_LAST);
        if (sync2[k] != stable[k]) begin
          if (db_cnt[k] == CNT_LAST) begin
            stable[k] <= sync2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rpt_cnt [2];
  logic [1:0]    rpt_ev;

  // Reload to DELAY-PERIOD so every later repeat lands PERIOD cycles apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_ev <= '0;
      for (int k = 0; k < 2; k++) rpt_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        rpt_ev[k] <= 1'b0;
        if (!stable[k] || !sif.enable) begin
          rpt_cnt[k] <= '0;
        end else if (rpt_cnt[k] == RW'(REPEAT_DELAY - 1)) begin
          rpt_ev[k]  <= 1'b1;
          rpt_cnt[k] <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
          rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign key_ev = press_ev | rpt_ev;
`else
  assign key_ev = press_ev;
`endif

  // Coincident inc and dec events cancel each other.
  logic ev_inc, ev_dec;
  assign ev_inc = key_ev[0] & ~key_ev[1];
  assign ev_dec = key_ev[1] & ~key_ev[0];

  state_t                 state, state_nxt;
  logic [SW-1:0]          tgt, tgt_nxt;
  logic                   go_inc, go_dec;
  logic [3:0]             levels [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] inc_q, dec_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    go_inc    = 1'b0;
    go_dec    = 1'b0;
    if (!sif.enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ev_inc) begin
            state_nxt = PEND_INC;
            tgt_nxt   = sif.sel;
          end else if (ev_dec) begin
            state_nxt = PEND_DEC;
            tgt_nxt   = sif.sel;
          end
        end
        PEND_INC: begin
          if (ev_dec) begin
            state_nxt = IDLE;
          end else if (sif.frame_en) begin
            if (levels[tgt] == LV_MAX) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = ISSUE;
              go_inc    = 1'b1;
            end
          end
        end
        PEND_DEC: begin
          if (ev_inc) begin
            state_nxt = IDLE;
          end else if (sif.frame_en) begin
            if (levels[tgt] == 4'd0) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = ISSUE;
              go_dec    = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q <= '0;
      dec_q <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) levels[i] <= LV_DEF;
    end else begin
      inc_q <= go_inc ? (NUM_FILTERS'(1) << tgt) : '0;
      dec_q <= go_dec ? (NUM_FILTERS'(1) << tgt) : '0;
      if (go_inc) levels[tgt] <= levels[tgt] + 4'd1;
      if (go_dec) levels[tgt] <= levels[tgt] - 4'd1;
    end
  end

  assign sif.inc     = inc_q;
  assign sif.dec     = dec_q;
  assign sif.level   = levels[sif.sel];
  assign sif.pending = (state == PEND_INC) || (state == PEND_DEC);
endmodule

// File: tb/tb_adjust_sched.sv
// Directed bench for adjust_sched with DEBOUNCE_CYCLES=4, four filters, levels 0..7 defaulting to 4.
`timescale 1ns/1ps
module tb_adjust_sched;
  localparam int NF = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adjust_sched_if #(.NUM_FILTERS(NF)) sif ();

  adjust_sched #(
    .DEBOUNCE_CYCLES(4),
    .NUM_FILTERS(NF),
    .LEVEL_MAX(7),
    .LEVEL_DEFAULT(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    sif.frame_en = 1'b1;
    tick(1);
    sif.frame_en = 1'b0;
  endtask

  // Press one key on filter s, hold it, fire one frame, then release.
  task automatic req(input string tag, input logic is_dec, input logic [1:0] s,
                     input logic [3:0] exp_inc, input logic [3:0] exp_dec,
                     input logic [3:0] exp_lvl);
    sif.sel = s;
    if (is_dec) sif.key_dec_n = 1'b0;
    else        sif.key_inc_n = 1'b0;
    tick(10);
    chk({tag, "/pend"}, 32'(sif.pending), 32'd1);
    frame();
    chk({tag, "/inc"}, 32'(sif.inc), 32'(exp_inc));
    chk({tag, "/dec"}, 32'(sif.dec), 32'(exp_dec));
    chk({tag, "/pend_clr"}, 32'(sif.pending), 32'd0);
    chk({tag, "/level"}, 32'(sif.level), 32'(exp_lvl));
    sif.key_inc_n = 1'b1;
    sif.key_dec_n = 1'b1;
    tick(1);
    chk({tag, "/one_cycle"}, 32'({sif.inc, sif.dec}), 32'd0);
    tick(10);
  endtask

  initial begin
    rst           = 1'b1;
    sif.enable    = 1'b1;
    sif.frame_en  = 1'b0;
    sif.key_inc_n = 1'b1;
    sif.key_dec_n = 1'b1;
    sif.sel       = 2'd0;
    tick(2);
    chk("rst/inc", 32'(sif.inc), 32'd0);
    chk("rst/dec", 32'(sif.dec), 32'd0);
    chk("rst/pend", 32'(sif.pending), 32'd0);
    chk("rst/level", 32'(sif.level), 32'd4);
    rst = 1'b0;
    tick(2);

    frame();
    chk("idle_frame", 32'({sif.inc, sif.dec}), 32'd0);
    tick(2);

`ifdef AUTOREPEAT_EN
    begin
      int pulses;
      pulses = 0;
      sif.sel       = 2'd2;
      sif.key_inc_n = 1'b0;
      for (int c = 0; c < 40; c++) begin
        sif.frame_en = (c % 5 == 4);
        tick(1);
        if (sif.inc != '0) pulses++;
      end
      sif.frame_en  = 1'b0;
      sif.key_inc_n = 1'b1;
      tick(12);
      chk("rpt/pulses", 32'(pulses), 32'd3);
      chk("rpt/level", 32'(sif.level), 32'd7);
    end
`else
    req("t1", 1'b0, 2'd2, 4'b0100, 4'b0000, 4'd5);

    sif.sel = 2'd2;
    for (int i = 0; i < 5; i++) begin
      sif.key_inc_n = 1'b0;
      tick(2);
      chk("bounce/pend_lo", 32'(sif.pending), 32'd0);
      sif.key_inc_n = 1'b1;
      tick(2);
      chk("bounce/pend_hi", 32'(sif.pending), 32'd0);
    end
    tick(10);
    chk("bounce/pend_end", 32'(sif.pending), 32'd0);
    chk("bounce/level", 32'(sif.level), 32'd5);

    req("sat1", 1'b0, 2'd1, 4'b0010, 4'b0000, 4'd5);
    req("sat2", 1'b0, 2'd1, 4'b0010, 4'b0000, 4'd6);
    req("sat3", 1'b0, 2'd1, 4'b0010, 4'b0000, 4'd7);
    req("sat4", 1'b0, 2'd1, 4'b0000, 4'b0000, 4'd7);

    sif.sel       = 2'd0;
    sif.key_inc_n = 1'b0;
    tick(10);
    chk("cancel/pend", 32'(sif.pending), 32'd1);
    sif.key_dec_n = 1'b0;
    tick(10);
    chk("cancel/pend_clr", 32'(sif.pending), 32'd0);
    frame();
    chk("cancel/no_pulse", 32'({sif.inc, sif.dec}), 32'd0);
    chk("cancel/level", 32'(sif.level), 32'd4);
    sif.key_inc_n = 1'b1;
    sif.key_dec_n = 1'b1;
    tick(10);

    sif.key_inc_n = 1'b0;
    sif.key_dec_n = 1'b0;
    tick(10);
    chk("both/pend", 32'(sif.pending), 32'd0);
    sif.key_inc_n = 1'b1;
    sif.key_dec_n = 1'b1;
    tick(10);

    sif.enable    = 1'b0;
    sif.key_inc_n = 1'b0;
    tick(10);
    chk("disabled/pend", 32'(sif.pending), 32'd0);
    frame();
    chk("disabled/no_pulse", 32'({sif.inc, sif.dec}), 32'd0);
    sif.key_inc_n = 1'b1;
    tick(10);
    sif.enable = 1'b1;
    tick(1);
    chk("disabled/level", 32'(sif.level), 32'd4);

    req("dec", 1'b1, 2'd0, 4'b0000, 4'b0001, 4'd3);

    sif.sel       = 2'd3;
    sif.key_inc_n = 1'b0;
    tick(10);
    chk("rstmid/pend", 32'(sif.pending), 32'd1);
    rst           = 1'b1;
    sif.key_inc_n = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstmid/pend_clr", 32'(sif.pending), 32'd0);
    chk("rstmid/inc", 32'(sif.inc), 32'd0);
    frame();
    chk("rstmid/no_pulse", 32'({sif.inc, sif.dec}), 32'd0);
    for (int i = 0; i < NF; i++) begin
      sif.sel = 2'(i);
      #1;
      chk("rstmid/level", 32'(sif.level), 32'd4);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
